hazard_forward_ctrl: RTL and testbench

//   Parametrised forwarding plus load-use hazard controller for the 5-stage pipeline.

---
 rtl/hazard_forward_ctrl_if.sv | 47 ++++
 rtl/hazard_forward_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for the forwarding / load-use hazard controller.
//   master : pipeline control (drives register specifiers and control bits, reads selects/stalls)
//   slave  : hazard_forward_ctrl
// Signals: ID / EX / MEM / WB register specifiers and write/read enables, flush,
//          forwarding selects fwd_a/fwd_b/fwd_c, stall_pc/stall_ifid/bubble_idex,
//          stall_cycles performance counter.
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_ex_rs;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic                  id_ex_memread;
    logic [REG_ADDR_W-1:0] ex_mem_rd;
    logic [REG_ADDR_W-1:0] ex_mem_rt;
    logic                  ex_mem_regwrite;
    logic                  ex_mem_memwrite;
    logic [REG_ADDR_W-1:0] mem_wb_rd;
    logic                  mem_wb_regwrite;
    logic                  flush;

    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  fwd_c;
    logic                  stall_pc;
    logic                  stall_ifid;
    logic                  bubble_idex;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_memread,
               ex_mem_rd, ex_mem_rt, ex_mem_regwrite, ex_mem_memwrite,
               mem_wb_rd, mem_wb_regwrite, flush,
        input  fwd_a, fwd_b, fwd_c, stall_pc, stall_ifid, bubble_idex, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_memread,
               ex_mem_rd, ex_mem_rt, ex_mem_regwrite, ex_mem_memwrite,
               mem_wb_rd, mem_wb_regwrite, flush,
        output fwd_a, fwd_b, fwd_c, stall_pc, stall_ifid, bubble_idex, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Ports:
//   clk     : pipeline clock, rising edge
//   reset_n : asynchronous active-low reset; also gates every output to 0 while low
//   bus     : hazard_forward_ctrl_if.slave (specifiers in, forwarding selects / stalls / counter out)
// Forwarding selects and the IDLE-state stall are combinational so the pipeline can
// react in the same cycle; a load-use hazard holds the stall for LOAD_LAT cycles.
module hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hazard_forward_ctrl_if.slave  bus
);
    localparam int unsigned CNT_BITS = 3;
    localparam logic [CNT_BITS-1:0] CNT_INIT =
        (LOAD_LAT > 1) ? CNT_BITS'(LOAD_LAT - 2) : '0;
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    typedef enum logic {IDLE, STALL} state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                stall_c;
    logic                hz;
    logic [1:0]          fwd_a_c, fwd_b_c;
    logic                fwd_c_c;
    logic                stall_g;
    logic [CNT_W-1:0]    stall_cycles_q;

    // Operand forwarding: EX/MEM result is newer, so it wins over MEM/WB.
    always_comb begin
        fwd_a_c = SEL_RF;
        fwd_b_c = SEL_RF;
        if (bus.ex_mem_regwrite && bus.ex_mem_rd != '0 && bus.ex_mem_rd == bus.id_ex_rs)
            fwd_a_c = SEL_MEM;
        else if (bus.mem_wb_regwrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.id_ex_rs)
            fwd_a_c = SEL_WB;
        if (bus.ex_mem_regwrite && bus.ex_mem_rd != '0 && bus.ex_mem_rd == bus.id_ex_rt)
            fwd_b_c = SEL_MEM;
        else if (bus.mem_wb_regwrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.id_ex_rt)
            fwd_b_c = SEL_WB;
    end

    // Store data in MEM taken from the value being written back.
    assign fwd_c_c = bus.ex_mem_memwrite && bus.mem_wb_regwrite &&
                     bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.ex_mem_rt;

    // Load in EX whose destination is read by the instruction in ID.
    assign hz = bus.id_ex_memread && bus.id_ex_rd != '0 &&
                (bus.id_ex_rd == bus.id_rs || (bus.id_uses_rt && bus.id_ex_rd == bus.id_rt));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and stall decode; cnt counts the remaining STALL cycles after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hz && !bus.flush) begin
                    stall_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            STALL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CNT_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_g = stall_c & reset_n;

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cycles_q <= '0;
        else if (stall_g && stall_cycles_q != '1)
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end

    assign bus.fwd_a        = reset_n ? fwd_a_c : SEL_RF;
    assign bus.fwd_b        = reset_n ? fwd_b_c : SEL_RF;
    assign bus.fwd_c        = fwd_c_c & reset_n;
    assign bus.stall_pc     = stall_g;
    assign bus.stall_ifid   = stall_g;
    assign bus.bubble_idex  = stall_g;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, LOAD_LAT=1/CNT_W=4)
// share one stimulus vector; per-cycle expectations come from hand-derived tables.
module tb_hazard_forward_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic [4:0] id_ex_rs;
        logic [4:0] id_ex_rt;
        logic [4:0] id_ex_rd;
        logic       id_ex_memread;
        logic [4:0] ex_mem_rd;
        logic [4:0] ex_mem_rt;
        logic       ex_mem_regwrite;
        logic       ex_mem_memwrite;
        logic [4:0] mem_wb_rd;
        logic       mem_wb_regwrite;
        logic       flush;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fc;
        logic       s1;   // stall expected from LOAD_LAT=1 instance
        logic       s3;   // stall expected from LOAD_LAT=3 instance
        logic       ss;   // stall expected from CNT_W=4 instance
    } vec_t;

    in_t cur;

    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) b1 ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) b3 ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bs ();

    assign {b1.id_rs, b1.id_rt, b1.id_uses_rt, b1.id_ex_rs, b1.id_ex_rt, b1.id_ex_rd, b1.id_ex_memread,
            b1.ex_mem_rd, b1.ex_mem_rt, b1.ex_mem_regwrite, b1.ex_mem_memwrite,
            b1.mem_wb_rd, b1.mem_wb_regwrite, b1.flush} = cur;
    assign {b3.id_rs, b3.id_rt, b3.id_uses_rt, b3.id_ex_rs, b3.id_ex_rt, b3.id_ex_rd, b3.id_ex_memread,
            b3.ex_mem_rd, b3.ex_mem_rt, b3.ex_mem_regwrite, b3.ex_mem_memwrite,
            b3.mem_wb_rd, b3.mem_wb_regwrite, b3.flush} = cur;
    assign {bs.id_rs, bs.id_rt, bs.id_uses_rt, bs.id_ex_rs, bs.id_ex_rt, bs.id_ex_rd, bs.id_ex_memread,
            bs.ex_mem_rd, bs.ex_mem_rt, bs.ex_mem_regwrite, bs.ex_mem_memwrite,
            bs.mem_wb_rd, bs.mem_wb_regwrite, bs.flush} = cur;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3));
    hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(4))  us (.clk(clk), .reset_n(reset_n), .bus(bs));

    int checks   = 0;
    int failures = 0;
    int e_cnt1   = 0;
    int e_cnt3   = 0;
    int e_cnts   = 0;
    vec_t exp_q[$];
    vec_t tbl[$];
    vec_t sat_tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " u1 fwd"},   {27'd0, b1.fwd_a, b1.fwd_b, b1.fwd_c}, 32'd0);
        chk({tag, " u1 stall"}, {29'd0, b1.stall_pc, b1.stall_ifid, b1.bubble_idex}, 32'd0);
        chk({tag, " u3 stall"}, {29'd0, b3.stall_pc, b3.stall_ifid, b3.bubble_idex}, 32'd0);
        chk({tag, " us stall"}, {29'd0, bs.stall_pc, bs.stall_ifid, bs.bubble_idex}, 32'd0);
        chk({tag, " u1 cnt"}, 32'(b1.stall_cycles), 32'd0);
        chk({tag, " u3 cnt"}, 32'(b3.stall_cycles), 32'd0);
        chk({tag, " us cnt"}, 32'(bs.stall_cycles), 32'd0);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic run_row(input vec_t v, input int idx);
        vec_t e;
        string t;
        @(posedge clk);
        #1;
        cur = v.in;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        t = $sformatf("row%0d", idx);
        chk({t, " fwd_a"}, 32'(b1.fwd_a), 32'(e.fa));
        chk({t, " fwd_b"}, 32'(b1.fwd_b), 32'(e.fb));
        chk({t, " fwd_c"}, 32'(b1.fwd_c), 32'(e.fc));
        chk({t, " u3 fwd"}, {27'd0, b3.fwd_a, b3.fwd_b, b3.fwd_c}, {27'd0, e.fa, e.fb, e.fc});
        chk({t, " u1 stalls"}, {29'd0, b1.stall_pc, b1.stall_ifid, b1.bubble_idex}, {29'd0, {3{e.s1}}});
        chk({t, " u3 stalls"}, {29'd0, b3.stall_pc, b3.stall_ifid, b3.bubble_idex}, {29'd0, {3{e.s3}}});
        chk({t, " us stall_pc"}, 32'(bs.stall_pc), 32'(e.ss));
        chk({t, " u1 cnt"}, 32'(b1.stall_cycles), 32'(e_cnt1));
        chk({t, " u3 cnt"}, 32'(b3.stall_cycles), 32'(e_cnt3));
        chk({t, " us cnt"}, 32'(bs.stall_cycles), 32'(e_cnts));
        e_cnt1 += int'(e.s1);
        e_cnt3 += int'(e.s3);
        if (e.ss && e_cnts < 15) e_cnts++;
    endtask

    initial begin
        vec_t v;
        in_t  hzin;
        in_t  fwdin;

        // Combinational forwarding vectors.
        v = '0; v.in.ex_mem_regwrite = 1; v.in.ex_mem_rd = 5; v.in.mem_wb_regwrite = 1;
        v.in.mem_wb_rd = 5; v.in.id_ex_rs = 5; v.fa = 2'b10; tbl.push_back(v);
        v = '0; v.in.id_ex_rs = 3; v.in.id_ex_rt = 4; v.in.ex_mem_rd = 3; v.in.mem_wb_rd = 4;
        v.in.ex_mem_regwrite = 1; v.in.mem_wb_regwrite = 1; v.fa = 2'b10; v.fb = 2'b01; tbl.push_back(v);
        v.in.ex_mem_rd = 0; v.in.mem_wb_rd = 0; v.fa = 2'b00; v.fb = 2'b00; tbl.push_back(v);
        v.in.id_ex_rs = 0; v.in.id_ex_rt = 0; tbl.push_back(v);
        v = '0; v.in.ex_mem_rd = 6; v.in.id_ex_rs = 6; v.in.id_ex_rt = 6; v.in.mem_wb_regwrite = 1;
        v.in.mem_wb_rd = 6; v.fa = 2'b01; v.fb = 2'b01; tbl.push_back(v);
        v = '0; v.in.ex_mem_memwrite = 1; v.in.ex_mem_rt = 7; v.in.mem_wb_regwrite = 1;
        v.in.mem_wb_rd = 7; v.fc = 1; tbl.push_back(v);
        v.in.mem_wb_rd = 0; v.fc = 0; tbl.push_back(v);
        v.in.mem_wb_rd = 7; v.in.ex_mem_memwrite = 0; tbl.push_back(v);

        // Load-use on rs: 1 cycle for LOAD_LAT=1, 3 cycles for LOAD_LAT=3.
        hzin = '0; hzin.id_ex_memread = 1; hzin.id_ex_rd = 8; hzin.id_rs = 8;
        v = '0; v.in = hzin; v.s1 = 1; v.s3 = 1; v.ss = 1; tbl.push_back(v);
        v = '0; v.s3 = 1; tbl.push_back(v);
        tbl.push_back(v);
        v = '0; tbl.push_back(v);

        // rt only matters when the ID instruction actually reads it.
        v = '0; v.in.id_ex_memread = 1; v.in.id_ex_rd = 9; v.in.id_rt = 9; v.in.id_rs = 1; tbl.push_back(v);
        v.in.id_uses_rt = 1; v.s1 = 1; v.s3 = 1; v.ss = 1; tbl.push_back(v);
        v = '0; v.s3 = 1; tbl.push_back(v);
        tbl.push_back(v);
        v = '0; tbl.push_back(v);

        // Flush beats a fresh hazard, then cancels a stall in progress.
        v = '0; v.in = hzin; v.in.flush = 1; tbl.push_back(v);
        v = '0; v.in = hzin; v.s1 = 1; v.s3 = 1; v.ss = 1; tbl.push_back(v);
        v = '0; v.in.flush = 1; tbl.push_back(v);
        v = '0; tbl.push_back(v);
        v = '0; v.in.id_ex_memread = 1; v.in.id_ex_rd = 0; v.in.id_rs = 0; tbl.push_back(v);

        // Persistent hazard: counter saturation on the 4-bit instance.
        for (int i = 0; i < 20; i++) begin
            v = '0; v.in = hzin; v.s1 = 1; v.s3 = 1; v.ss = 1; sat_tbl.push_back(v);
        end
        v = '0; v.s3 = 1; sat_tbl.push_back(v);
        v = '0; sat_tbl.push_back(v);

        // Reset state, with inputs that would otherwise forward and stall.
        fwdin = tbl[0].in;
        fwdin.ex_mem_memwrite = 1; fwdin.ex_mem_rt = 5;
        fwdin.id_ex_memread = 1; fwdin.id_ex_rd = 8; fwdin.id_rs = 8;
        cur = fwdin;
        reset_n = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        cur = '0;
        reset_n = 1'b1;

        foreach (tbl[i]) run_row(tbl[i], i);

        // Reset asserted in the 2nd cycle of a LOAD_LAT=3 stall.
        v = '0; v.in = hzin; v.s1 = 1; v.s3 = 1; v.ss = 1; run_row(v, 100);
        v = '0; v.s3 = 1; run_row(v, 101);
        #2;
        cur = fwdin;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midstall_reset");
        e_cnt1 = 0; e_cnt3 = 0; e_cnts = 0;
        @(negedge clk);
        cur = '0;
        reset_n = 1'b1;
        v = '0; run_row(v, 102);

        foreach (sat_tbl[i]) run_row(sat_tbl[i], 200 + i);
        chk("sat us cnt", 32'(bs.stall_cycles), 32'd15);
        chk("sat u1 cnt", 32'(b1.stall_cycles), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
